// File: rtl/pbuff_ctrl_pkg.sv
// rtl/pbuff_ctrl_pkg.sv - sizing defaults and FSM encoding for the partial line buffer sequencer
`ifndef PBUFF_CTRL_DEFS
`define PBUFF_CTRL_DEFS
`define PBC_HWIDTH   640
`define PBC_AWIDTH   10
`define PBC_DWIDTH   12
`define PBC_DEPTH    3
`define PBC_IDLE     2'd0
`define PBC_POP      2'd1
`define PBC_SWEEP    2'd2
`endif

package pbuff_ctrl_pkg;

  localparam int HWIDTH_DEF = `PBC_HWIDTH;
  localparam int AWIDTH_DEF = `PBC_AWIDTH;
  localparam int DWIDTH_DEF = `PBC_DWIDTH;
  localparam int DEPTH_DEF  = `PBC_DEPTH;

  typedef enum logic [1:0] {
    ST_IDLE  = `PBC_IDLE,
    ST_POP   = `PBC_POP,
    ST_SWEEP = `PBC_SWEEP
  } pbc_state_e;

endpackage

// File: rtl/pbuff_ctrl_wr_seq.sv
// rtl/pbuff_ctrl_wr_seq.sv - write column counter, line-end detection and pending-commit tracking
module pbuff_wr_seq
  import pbuff_ctrl_pkg::*;
#(
  parameter int HWIDTH = HWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic              pix_eol,
  input  logic              pend_clr,
  output logic [AWIDTH-1:0] wcol,
  output logic              line_pend,
  output logic              overflow
);

  localparam logic [AWIDTH-1:0] LAST_COL = AWIDTH'(HWIDTH - 1);

  logic [AWIDTH-1:0] wcol_q, wcol_d;
  logic              line_pend_q, line_pend_d;
  logic              overflow_q, overflow_d;
  logic              line_end;

  always_comb begin
    line_end    = pix_valid && (pix_eol || (wcol_q == LAST_COL));
    wcol_d      = wcol_q;
    line_pend_d = line_pend_q;
    overflow_d  = overflow_q;
    if (frame_start) begin
      wcol_d      = '0;
      line_pend_d = 1'b0;
      overflow_d  = 1'b0;
    end else begin
      if (line_end) begin
        wcol_d = '0;
      end else if (pix_valid) begin
        wcol_d = wcol_q + 1'b1;
      end
      // A line end coinciding with the commit re-arms the flag without loss.
      if (line_end) begin
        line_pend_d = 1'b1;
        if (line_pend_q && !pend_clr) begin
          overflow_d = 1'b1;
        end
      end else if (pend_clr) begin
        line_pend_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wcol_q      <= '0;
      line_pend_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      wcol_q      <= wcol_d;
      line_pend_q <= line_pend_d;
      overflow_q  <= overflow_d;
    end
  end

  assign wcol      = wcol_q;
  assign line_pend = line_pend_q;
  assign overflow  = overflow_q;

endmodule

// File: rtl/pbuff_ctrl.sv
// rtl/pbuff_ctrl.sv - partial line buffer sequencer: pixel writes, line commit pops and column read sweep
module pbuff_ctrl
  import pbuff_ctrl_pkg::*;
#(
  parameter int HWIDTH = HWIDTH_DEF,
  parameter int AWIDTH = AWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              pix_valid,
  input  logic [DWIDTH-1:0] pix_data,
  input  logic              pix_eol,
  output logic              pb_wen,
  output logic [AWIDTH-1:0] pb_waddr,
  output logic [DWIDTH-1:0] pb_wdata,
  output logic              pb_pop,
  output logic [AWIDTH-1:0] pb_raddr,
  output logic              col_valid,
  output logic              col_last,
  input  logic              col_ready,
  output logic              lines_primed,
  output logic              overflow
);

  localparam int                LCW      = $clog2(DEPTH + 1);
  localparam logic [LCW-1:0]    LC_FULL  = LCW'(DEPTH);
  localparam logic [AWIDTH-1:0] LAST_COL = AWIDTH'(HWIDTH - 1);

  pbc_state_e        state_q, state_d;
  logic [AWIDTH-1:0] rcol_q, rcol_d;
  logic [LCW-1:0]    lcount_q, lcount_d;
  logic [AWIDTH-1:0] wcol;
  logic              line_pend;
  logic              pend_clr;

  pbuff_wr_seq #(
    .HWIDTH (HWIDTH),
    .AWIDTH (AWIDTH)
  ) u_wr_seq (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_valid   (pix_valid),
    .pix_eol     (pix_eol),
    .pend_clr    (pend_clr),
    .wcol        (wcol),
    .line_pend   (line_pend),
    .overflow    (overflow)
  );

  assign pb_wen       = pix_valid;
  assign pb_waddr     = wcol;
  assign pb_wdata     = pix_data;
  assign lines_primed = (lcount_q == LC_FULL);

  always_comb begin
    state_d   = state_q;
    rcol_d    = rcol_q;
    lcount_d  = frame_start ? '0 : lcount_q;
    pb_pop    = 1'b0;
    pend_clr  = 1'b0;
    col_valid = 1'b0;
    col_last  = 1'b0;
    pb_raddr  = '0;
    case (state_q)
      ST_IDLE: begin
        if (line_pend) begin
          state_d = ST_POP;
        end
      end
      ST_POP: begin
        pb_pop   = 1'b1;
        pend_clr = 1'b1;
        if (!frame_start && (lcount_q != LC_FULL)) begin
          lcount_d = lcount_q + 1'b1;
        end
        state_d = (lcount_d == LC_FULL) ? ST_SWEEP : ST_IDLE;
      end
      ST_SWEEP: begin
        // A frame_start here lets the sweep run out; only accounting restarts.
        col_valid = 1'b1;
        pb_raddr  = rcol_q;
        col_last  = (rcol_q == LAST_COL);
        if (col_ready) begin
          if (rcol_q == LAST_COL) begin
            rcol_d  = '0;
            state_d = ST_IDLE;
          end else begin
            rcol_d = rcol_q + 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rcol_q   <= '0;
      lcount_q <= '0;
    end else begin
      state_q  <= state_d;
      rcol_q   <= rcol_d;
      lcount_q <= lcount_d;
    end
  end

endmodule

// File: tb/tb_pbuff_ctrl.sv
// tb/tb_pbuff_ctrl.sv - scoreboard bench for pbuff_ctrl: writes, pops and column sweeps
module tb_pbuff_ctrl;

  localparam int HW = 640;
  localparam int AW = 10;
  localparam int DW = 12;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic          pix_valid = 1'b0;
  logic [DW-1:0] pix_data = '0;
  logic          pix_eol = 1'b0;
  logic          col_ready = 1'b1;
  logic          pb_wen, pb_pop, col_valid, col_last, lines_primed, overflow;
  logic [AW-1:0] pb_waddr, pb_raddr;
  logic [DW-1:0] pb_wdata;

  pbuff_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .frame_start  (frame_start),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_eol      (pix_eol),
    .pb_wen       (pb_wen),
    .pb_waddr     (pb_waddr),
    .pb_wdata     (pb_wdata),
    .pb_pop       (pb_pop),
    .pb_raddr     (pb_raddr),
    .col_valid    (col_valid),
    .col_last     (col_last),
    .col_ready    (col_ready),
    .lines_primed (lines_primed),
    .overflow     (overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit is_col;
    int addr;
    bit last;
  } ev_t;

  ev_t eq[$];
  int  wq_addr[$];
  int  wq_data[$];
  int  n_cmp = 0;
  int  n_err = 0;
  int  ready_mode = 0;
  int  sweep_cyc = 0;
  int  last_sweep_len = 0;
  int  sweep_count = 0;
  int  exp_wcol = 0;
  int  data_seq = 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: drives col_ready for the current cycle, then checks observed events.
  initial begin
    ev_t e;
    forever begin
      @(negedge clk);
      col_ready = (ready_mode == 0) ? 1'b1 : sweep_cyc[0];
      if (rst) begin
        sweep_cyc = 0;
      end else begin
        if (pb_wen) begin
          chk("write_expected", int'(wq_addr.size() > 0), 1);
          if (wq_addr.size() > 0) begin
            chk("waddr", int'(pb_waddr), wq_addr.pop_front());
            chk("wdata", int'(pb_wdata), wq_data.pop_front());
          end
        end
        if (pb_pop) begin
          chk("pop_outside_sweep", int'(col_valid), 0);
          chk("pop_expected", int'(eq.size() > 0), 1);
          if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("pop_order", int'(e.is_col), 0);
          end
        end
        if (col_valid) begin
          sweep_cyc++;
          if (col_ready) begin
            chk("col_expected", int'(eq.size() > 0), 1);
            if (eq.size() > 0) begin
              e = eq.pop_front();
              chk("col_order", int'(e.is_col), 1);
              chk("raddr", int'(pb_raddr), e.addr);
              chk("col_last", int'(col_last), int'(e.last));
            end
            if (col_last) begin
              last_sweep_len = sweep_cyc;
              sweep_cyc = 0;
              sweep_count++;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_pixel(input bit eol);
    pix_valid = 1'b1;
    pix_eol   = eol;
    pix_data  = DW'(data_seq);
    data_seq  = data_seq + 37;
    wq_addr.push_back(exp_wcol);
    wq_data.push_back(int'(pix_data));
    exp_wcol = (eol || exp_wcol == HW - 1) ? 0 : exp_wcol + 1;
    tick();
    pix_valid = 1'b0;
    pix_eol   = 1'b0;
  endtask

  task automatic send_line(input int n, input bit eol_last);
    for (int i = 0; i < n; i++) send_pixel(eol_last && (i == n - 1));
    idle(16);
  endtask

  task automatic push_pop();
    ev_t e;
    e.is_col = 1'b0;
    e.addr   = 0;
    e.last   = 1'b0;
    eq.push_back(e);
  endtask

  task automatic push_sweep(input int n);
    ev_t e;
    for (int i = 0; i < n; i++) begin
      e.is_col = 1'b1;
      e.addr   = i;
      e.last   = (i == HW - 1);
      eq.push_back(e);
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int c = 0;
    while ((eq.size() != 0 || wq_addr.size() != 0) && c < budget) begin
      tick();
      c++;
    end
    chk(name, eq.size(), 0);
    idle(4);
  endtask

  task automatic wait_sweeps(input string name, input int target, input int budget);
    int c = 0;
    while (sweep_count < target && c < budget) begin
      tick();
      c++;
    end
    chk(name, sweep_count, target);
  endtask

  initial begin
    int c;
    rst = 1'b1;
    idle(3);
    chk("rst_pb_wen", int'(pb_wen), 0);
    chk("rst_pb_pop", int'(pb_pop), 0);
    chk("rst_col_valid", int'(col_valid), 0);
    chk("rst_col_last", int'(col_last), 0);
    chk("rst_pb_raddr", int'(pb_raddr), 0);
    chk("rst_pb_waddr", int'(pb_waddr), 0);
    chk("rst_lines_primed", int'(lines_primed), 0);
    chk("rst_overflow", int'(overflow), 0);
    rst = 1'b0;
    idle(2);

    // Prime with three full lines, one sweep at full rate
    push_pop(); push_pop(); push_pop(); push_sweep(HW);
    send_line(HW, 1'b1);
    send_line(HW, 1'b1);
    chk("primed_after_2_lines", int'(lines_primed), 0);
    send_line(HW, 1'b1);
    chk("primed_after_3_lines", int'(lines_primed), 1);
    wait_drain("p1_drain", 2000);
    chk("p1_sweep_count", sweep_count, 1);
    chk("p1_sweep_len", last_sweep_len, HW);

    // Throttled sweep; 5th line's pop is deferred until it ends
    ready_mode = 1;
    push_pop(); push_sweep(HW); push_pop(); push_sweep(HW);
    send_line(HW, 1'b1);
    send_line(HW, 1'b1);
    wait_sweeps("p2_sweep_done", 2, 3000);
    chk("p2_sweep_len", last_sweep_len, 2 * HW);
    ready_mode = 0;
    wait_drain("p2_drain", 2000);
    chk("p2_overflow", int'(overflow), 0);
    chk("p2_sweep_count", sweep_count, 3);

    // Two short lines during one sweep -> overflow, single pop
    push_pop(); push_sweep(HW); push_pop(); push_sweep(HW);
    send_line(HW, 1'b1);
    send_line(8, 1'b1);
    send_line(8, 1'b1);
    chk("p3_overflow_set", int'(overflow), 1);
    wait_drain("p3_drain", 3000);
    chk("p3_overflow_sticky", int'(overflow), 1);
    chk("p3_sweep_count", sweep_count, 5);

    // frame_start restarts accounting; implicit wrap and short-line restart
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_wcol = 0;
    chk("fs_overflow_clr", int'(overflow), 0);
    chk("fs_primed_clr", int'(lines_primed), 0);
    push_pop(); push_pop();
    send_line(HW, 1'b0);
    send_line(10, 1'b1);
    chk("fs_2_lines_unprimed", int'(lines_primed), 0);
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    exp_wcol = 0;
    chk("fs2_primed_clr", int'(lines_primed), 0);
    push_pop(); push_pop();
    send_line(100, 1'b1);
    send_line(10, 1'b1);
    chk("fs2_2_lines_unprimed", int'(lines_primed), 0);
    chk("fs2_no_sweep", sweep_count, 5);
    push_pop(); push_sweep(HW);
    send_line(10, 1'b1);
    chk("fs2_3rd_line_primed", int'(lines_primed), 1);
    wait_drain("p4_drain", 2000);
    chk("p4_sweep_count", sweep_count, 6);

    // Reset in the middle of a sweep
    push_pop(); push_sweep(300);
    send_line(10, 1'b1);
    c = 0;
    while (!(col_valid && pb_raddr == AW'(300)) && c < 2000) begin
      tick();
      c++;
    end
    chk("p6_reach_rcol_300", int'(pb_raddr), 300);
    rst = 1'b1;
    tick();
    chk("midrst_col_valid", int'(col_valid), 0);
    chk("midrst_pb_raddr", int'(pb_raddr), 0);
    chk("midrst_pb_pop", int'(pb_pop), 0);
    chk("midrst_lines_primed", int'(lines_primed), 0);
    chk("midrst_overflow", int'(overflow), 0);
    rst = 1'b0;
    exp_wcol = 0;
    idle(4);
    chk("midrst_pb_pop_after", int'(pb_pop), 0);
    chk("final_event_queue", eq.size(), 0);
    chk("final_write_queue", wq_addr.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
